// File: rtl/conv_mac_seq_if.sv
// Handshake/bus bundle for the convolution MAC loop sequencer.
//   master : the sequencer (drives beats, flags, busy/done; samples start, cfg, oks)
//   slave  : the job launcher / buffer side (drives start, cfg, oks)
//   start          job launch pulse
//   cfg_*_max      loop bounds minus one (groups, reduction steps, Wout pixels)
//   wt_ok/dat_ok   buffer can supply a word this cycle
//   wt_vld/wt_cnt  weight beat and its row index
//   dat_vld        data beat, qualified by the four loop-boundary flags
//   busy/done      job in progress / one-cycle completion pulse
interface conv_mac_seq_if #(
  parameter int TOUT  = 32,
  parameter int CNT_W = 16
);
  localparam int WT_W = (TOUT > 1) ? $clog2(TOUT) : 1;

  logic             start;
  logic [CNT_W-1:0] cfg_tout_max;
  logic [CNT_W-1:0] cfg_k_max;
  logic [CNT_W-1:0] cfg_wout_max;
  logic             wt_ok;
  logic             dat_ok;
  logic             wt_vld;
  logic [WT_W-1:0]  wt_cnt;
  logic             dat_vld;
  logic             CHinKyKx_max_now;
  logic             Wout_loop_start;
  logic             Wout_loop_end;
  logic             CHinKyKxWout_loop_end;
  logic             busy;
  logic             done;

  modport master (
    input  start, cfg_tout_max, cfg_k_max, cfg_wout_max, wt_ok, dat_ok,
    output wt_vld, wt_cnt, dat_vld, CHinKyKx_max_now, Wout_loop_start,
           Wout_loop_end, CHinKyKxWout_loop_end, busy, done
  );

  modport slave (
    output start, cfg_tout_max, cfg_k_max, cfg_wout_max, wt_ok, dat_ok,
    input  wt_vld, wt_cnt, dat_vld, CHinKyKx_max_now, Wout_loop_start,
           Wout_loop_end, CHinKyKxWout_loop_end, busy, done
  );
endinterface

// File: rtl/conv_mac_seq.sv
// Loop sequencer for the systolic convolution MAC array.
// Walks group -> reduction step -> Wout pixel. Per (group, step) it issues
// TOUT weight beats, then Wout data beats tagged with loop-boundary flags,
// then after the last beat waits out the MAC/accumulation latency and
// pulses done.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : conv_mac_seq_if.master (start/cfg/oks in; beats, flags, busy/done out)
// All outputs are registered: the issue decision taken in cycle n shows up
// on the outputs in cycle n+1.
module conv_mac_seq #(
  parameter int TOUT      = 32,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 8
) (
  input  logic           clk,
  input  logic           rst,
  conv_mac_seq_if.master bus
);
  localparam int WT_W = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam int DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WT, S_DAT, S_DRAIN, S_DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] tout_max_q, k_max_q, wout_max_q;
  logic [CNT_W-1:0] g, g_n, k, k_n, w, w_n;
  logic [WT_W-1:0]  r, r_n;
  logic [DR_W-1:0]  dcnt, dcnt_n;
  logic             latch;

  logic             wt_vld_q, wt_vld_n;
  logic [WT_W-1:0]  wt_cnt_q, wt_cnt_n;
  logic             dat_vld_q, dat_vld_n;
  logic             kmax_q, kmax_n;
  logic             ws_q, ws_n;
  logic             we_q, we_n;
  logic             all_q, all_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  logic             w_last, k_last;

  assign w_last = (w == wout_max_q);
  assign k_last = (k == k_max_q);

  always_comb begin
    state_n  = state;
    g_n      = g;
    k_n      = k;
    w_n      = w;
    r_n      = r;
    dcnt_n   = dcnt;
    latch    = 1'b0;
    wt_vld_n = 1'b0;
    wt_cnt_n = '0;
    dat_vld_n = 1'b0;
    kmax_n   = 1'b0;
    ws_n     = 1'b0;
    we_n     = 1'b0;
    all_n    = 1'b0;
    case (state)
      S_IDLE: begin
        // done_q is still high in the cycle right after DONE; a start seen
        // then is dropped so back-to-back jobs are spaced by the pulse.
        if (bus.start && !done_q) begin
          latch   = 1'b1;
          g_n     = '0;
          k_n     = '0;
          w_n     = '0;
          r_n     = '0;
          state_n = S_WT;
        end
      end
      S_WT: begin
        if (bus.wt_ok) begin
          wt_vld_n = 1'b1;
          wt_cnt_n = r;
          if (r == WT_W'(TOUT - 1)) begin
            r_n     = '0;
            state_n = S_DAT;
          end else begin
            r_n = r + 1'b1;
          end
        end
      end
      S_DAT: begin
        if (bus.dat_ok) begin
          dat_vld_n = 1'b1;
          ws_n      = (w == '0);
          we_n      = w_last;
          kmax_n    = k_last;
          all_n     = w_last && k_last;
          if (!w_last) begin
            w_n = w + 1'b1;
          end else begin
            w_n = '0;
            if (k < k_max_q) begin
              k_n     = k + 1'b1;
              state_n = S_WT;
            end else if (g < tout_max_q) begin
              k_n     = '0;
              g_n     = g + 1'b1;
              state_n = S_WT;
            end else begin
              dcnt_n  = '0;
              state_n = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (dcnt == DR_W'(DRAIN_CYC - 1)) state_n = S_DONE;
        else                              dcnt_n  = dcnt + 1'b1;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // busy covers the DONE state so it falls exactly when done rises.
    busy_n = (state_n != S_IDLE);
    done_n = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tout_max_q <= '0;
      k_max_q    <= '0;
      wout_max_q <= '0;
      g          <= '0;
      k          <= '0;
      w          <= '0;
      r          <= '0;
      dcnt       <= '0;
      wt_vld_q   <= 1'b0;
      wt_cnt_q   <= '0;
      dat_vld_q  <= 1'b0;
      kmax_q     <= 1'b0;
      ws_q       <= 1'b0;
      we_q       <= 1'b0;
      all_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state     <= state_n;
      g         <= g_n;
      k         <= k_n;
      w         <= w_n;
      r         <= r_n;
      dcnt      <= dcnt_n;
      wt_vld_q  <= wt_vld_n;
      wt_cnt_q  <= wt_cnt_n;
      dat_vld_q <= dat_vld_n;
      kmax_q    <= kmax_n;
      ws_q      <= ws_n;
      we_q      <= we_n;
      all_q     <= all_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      if (latch) begin
        tout_max_q <= bus.cfg_tout_max;
        k_max_q    <= bus.cfg_k_max;
        wout_max_q <= bus.cfg_wout_max;
      end
    end
  end

  assign bus.wt_vld                = wt_vld_q;
  assign bus.wt_cnt                = wt_cnt_q;
  assign bus.dat_vld               = dat_vld_q;
  assign bus.CHinKyKx_max_now      = kmax_q;
  assign bus.Wout_loop_start       = ws_q;
  assign bus.Wout_loop_end         = we_q;
  assign bus.CHinKyKxWout_loop_end = all_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;
endmodule

// File: tb/tb_conv_mac_seq.sv
// Self-checking bench for conv_mac_seq. Beats are recorded as codes:
// weight beat = 100 + row, data beat = 200 + {kmax, start, end, all_end}.
module tb_conv_mac_seq;
  localparam int TOUT      = 4;
  localparam int CNT_W     = 16;
  localparam int DRAIN_CYC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mac_seq_if #(.TOUT(TOUT), .CNT_W(CNT_W)) bus ();

  conv_mac_seq #(.TOUT(TOUT), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int obs[$];
  int viol = 0;
  int viol_base = 0;
  int last_dat_cyc = 0;
  logic wt_ok_e = 1'b0;
  logic dat_ok_e = 1'b0;

  // ok values the DUT actually sampled at this edge
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    wt_ok_e  <= bus.wt_ok;
    dat_ok_e <= bus.dat_ok;
  end

  always @(negedge clk) begin
    if (bus.wt_vld) begin
      obs.push_back(100 + int'(bus.wt_cnt));
      if (!wt_ok_e) viol <= viol + 1;
    end
    if (bus.dat_vld) begin
      obs.push_back(200 + int'({bus.CHinKyKx_max_now, bus.Wout_loop_start,
                                bus.Wout_loop_end, bus.CHinKyKxWout_loop_end}));
      last_dat_cyc <= cyc;
      if (!dat_ok_e) viol <= viol + 1;
    end else if (bus.CHinKyKx_max_now || bus.Wout_loop_start ||
                 bus.Wout_loop_end || bus.CHinKyKxWout_loop_end) begin
      viol <= viol + 1;
    end
  end

  function automatic logic [9:0] outs_vec();
    return {bus.wt_vld, bus.wt_cnt, bus.dat_vld, bus.CHinKyKx_max_now,
            bus.Wout_loop_start, bus.Wout_loop_end, bus.CHinKyKxWout_loop_end,
            bus.busy, bus.done};
  endfunction

  task automatic start_job(input int tm, input int km, input int wm);
    @(posedge clk); #2;
    bus.cfg_tout_max = CNT_W'(tm);
    bus.cfg_k_max    = CNT_W'(km);
    bus.cfg_wout_max = CNT_W'(wm);
    obs.delete();
    viol_base = viol;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy got=%b exp=1", bus.busy);
    end
  endtask

  task automatic wait_done(input bit stall, input bit disturb, output int dc);
    bit seen = 0;
    dc = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (stall) begin
        bus.wt_ok  = 1'($urandom_range(0, 1));
        bus.dat_ok = 1'($urandom_range(0, 1));
      end else begin
        bus.wt_ok  = 1'b1;
        bus.dat_ok = 1'b1;
      end
      if (disturb && i >= 2 && i < 6) begin
        bus.start        = 1'b1;
        bus.cfg_tout_max = CNT_W'($urandom);
        bus.cfg_k_max    = CNT_W'($urandom);
        bus.cfg_wout_max = CNT_W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #2;
      if (bus.done === 1'b1) begin
        seen = 1;
        dc = cyc;
      end
    end
    bus.start  = 1'b0;
    bus.wt_ok  = 1'b1;
    bus.dat_ok = 1'b1;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout got=no_done exp=done");
    end
  endtask

  // Reference: the job is a plain loop nest over the configured bounds.
  task automatic check_job(input int tm, input int km, input int wm, input int dc,
                           input string name);
    int exp[$];
    int nw = 0;
    int nd = 0;
    int bad = -1;
    for (int g = 0; g <= tm; g++)
      for (int k = 0; k <= km; k++) begin
        for (int r = 0; r < TOUT; r++) exp.push_back(100 + r);
        for (int w = 0; w <= wm; w++)
          exp.push_back(200 + 8 * int'(k == km) + 4 * int'(w == 0) +
                        2 * int'(w == wm) + int'(k == km && w == wm));
      end
    checks++;
    if (obs.size() != exp.size()) begin
      failures++;
      $display("FAIL %s seq_len got=%0d exp=%0d", name, obs.size(), exp.size());
    end else begin
      foreach (exp[i]) if (bad < 0 && obs[i] != exp[i]) bad = i;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s seq idx=%0d got=%0d exp=%0d", name, bad, obs[bad], exp[bad]);
      end
    end
    foreach (obs[i]) begin
      if (obs[i] < 200) nw++;
      else nd++;
    end
    checks++;
    if (nw != (tm + 1) * (km + 1) * TOUT || nd != (tm + 1) * (km + 1) * (wm + 1)) begin
      failures++;
      $display("FAIL %s totals got=%0d/%0d exp=%0d/%0d", name, nw, nd,
               (tm + 1) * (km + 1) * TOUT, (tm + 1) * (km + 1) * (wm + 1));
    end
    checks++;
    if (dc - last_dat_cyc != DRAIN_CYC + 1) begin
      failures++;
      $display("FAIL %s done_latency got=%0d exp=%0d", name, dc - last_dat_cyc, DRAIN_CYC + 1);
    end
    checks++;
    if (viol - viol_base != 0) begin
      failures++;
      $display("FAIL %s beat_rules got=%0d exp=0", name, viol - viol_base);
    end
  endtask

  task automatic run_job(input int tm, input int km, input int wm, input bit stall,
                         input bit disturb, input string name);
    int dc;
    start_job(tm, km, wm);
    wait_done(stall, disturb, dc);
    check_job(tm, km, wm, dc, name);
    @(posedge clk); #2;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse got=%b%b exp=00", name, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (outs_vec() !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0", outs_vec());
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (outs_vec() !== '0) begin
      failures++;
      $display("FAIL idle_outs got=%b exp=0", outs_vec());
    end
  endtask

  task automatic test_single();
    int lit[5] = '{100, 101, 102, 103, 215};
    bit ok = 1;
    run_job(0, 0, 0, 0, 0, "single");
    checks++;
    if (obs.size() != 5) ok = 0;
    else foreach (lit[i]) if (obs[i] != lit[i]) ok = 0;
    if (!ok) begin
      failures++;
      $display("FAIL single_literal got=%p exp=%p", obs, lit);
    end
  endtask

  task automatic test_flags();
    int dlit[6] = '{204, 200, 202, 212, 208, 211};
    int dobs[$];
    bit ok = 1;
    run_job(0, 1, 2, 0, 0, "flags");
    foreach (obs[i]) if (obs[i] >= 200) dobs.push_back(obs[i]);
    checks++;
    if (dobs.size() != 6) ok = 0;
    else foreach (dlit[i]) if (dobs[i] != dlit[i]) ok = 0;
    if (!ok) begin
      failures++;
      $display("FAIL flags_literal got=%p exp=%p", dobs, dlit);
    end
  endtask

  task automatic test_groups();
    int nend = 0;
    run_job(2, 0, 1, 0, 0, "groups");
    foreach (obs[i]) if (obs[i] >= 200 && (obs[i] % 2) == 1) nend++;
    checks++;
    if (nend != 3) begin
      failures++;
      $display("FAIL groups_loop_end got=%0d exp=3", nend);
    end
  endtask

  task automatic test_stall();
    run_job(0, 1, 2, 1, 0, "stall_a");
    run_job(2, 0, 1, 1, 0, "stall_b");
    for (int j = 0; j < 4; j++)
      run_job(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 4)), 1, 0, "stall_rand");
  endtask

  task automatic test_disturb();
    run_job(1, 1, 2, 0, 1, "disturb");
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int bad = 0;
    start_job(0, 3, 5);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #2;
      if (bus.dat_vld === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_mid_reach_dat got=0 exp=1");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_vec() !== '0) begin
      failures++;
      $display("FAIL rst_mid_outs got=%b exp=0", outs_vec());
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk); #2;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_no_done got=%0d exp=0", bad);
    end
    run_job(0, 1, 2, 0, 0, "post_rst");
  endtask

  task automatic test_back_to_back();
    int dc;
    start_job(1, 0, 1);
    wait_done(0, 0, dc);
    check_job(1, 0, 1, dc, "b2b_a");
    bus.start = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ignore got=%b%b exp=00", bus.busy, bus.done);
    end
    obs.delete();
    viol_base = viol;
    bus.cfg_tout_max = CNT_W'(0);
    bus.cfg_k_max    = CNT_W'(1);
    bus.cfg_wout_max = CNT_W'(1);
    @(posedge clk); #2;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept got=%b exp=1", bus.busy);
    end
    wait_done(0, 0, dc);
    check_job(0, 1, 1, dc, "b2b_b");
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_tout_max = '0;
    bus.cfg_k_max = '0;
    bus.cfg_wout_max = '0;
    bus.wt_ok = 1'b1;
    bus.dat_ok = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_flags();
    test_groups();
    test_stall();
    test_disturb();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_mac_seq.md
# conv_mac_seq

Loop sequencer for the systolic convolution MAC array. After a `start` pulse it walks a three-level loop nest: output-channel group, then the CHin·Ky·Kx reduction step, then Wout pixels. For each group and reduction step it first issues Tout weight beats, then streams Wout data beats together with the loop-boundary flags consumed by the MAC/accumulation pipeline. After the final beat it waits out the pipeline latency, then pulses `done`.

## Interface
- `TOUT`, 32: weight beats per reduction step (rows of the array); `wt_cnt` width is log2(TOUT).
- `CNT_W`, 16: width of every loop counter and config field.
- `DRAIN_CYC`, 8: cycles from the last data beat until `done` (MAC plus accumulation latency).

- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `cfg_tout_max`  in  CNT_W  number of output-channel groups minus 1.
- `cfg_k_max`  in  CNT_W  number of CHin·Ky·Kx steps minus 1.
- `cfg_wout_max`  in  CNT_W  Wout minus 1.
- `wt_ok`  in  1  weight buffer can supply a word this cycle.
- `dat_ok`  in  1  data buffer can supply a word this cycle.
- `wt_vld`  out  1  weight beat issued.
- `wt_cnt`  out  log2(TOUT)  row index of the weight beat.
- `dat_vld`  out  1  data beat issued.
- `CHinKyKx_max_now`  out  1  current beat belongs to the last reduction step.
- `Wout_loop_start`  out  1  current beat is pixel 0.
- `Wout_loop_end`  out  1  current beat is pixel `cfg_wout_max`.
- `CHinKyKxWout_loop_end`  out  1  last pixel of the last reduction step, i.e. a group is complete.
- `busy`  out  1  high from the cycle after `start` is accepted until `done` is asserted.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Config fields are latched into shadow registers when `start` is accepted. Changing the inputs while busy has no effect.
- States:
  - IDLE: on `start`, latch config, clear the counters g/k/w/r, go to WT.
  - WT: each cycle with `wt_ok` issues a weight beat with `wt_cnt=r` and increments r. When the beat with r==TOUT-1 is issued, clear r and go to DAT.
  - DAT: each cycle with `dat_ok` issues a data beat for pixel w.
    - If w<wout_max: increment w.
    - Else clear w, then:
      - if k<k_max: increment k and go to WT;
      - else if g<tout_max: clear k, increment g, go to WT;
      - else go to DRAIN.
  - DRAIN: count DRAIN_CYC cycles, then go to DONE.
  - DONE: assert `done` for one cycle, return to IDLE.
- Flag values on a data beat:
  - `Wout_loop_start` = (w==0).
  - `Wout_loop_end` = (w==wout_max).
  - `CHinKyKx_max_now` = (k==k_max).
  - `CHinKyKxWout_loop_end` = both of the last two conditions.
- All flags are 0 whenever `dat_vld`=0.
- Stalls: when `wt_ok`/`dat_ok` is low, no beat is issued and the counters hold. There is no limit on stall length.
- Totals per job:
  - weight beats = (tout_max+1)(k_max+1)·TOUT;
  - data beats = (tout_max+1)(k_max+1)(wout_max+1).
- `start` while busy is ignored. `start` in the DONE cycle is ignored.
- `rst` at any point (including mid-job) returns the block to IDLE with all counters cleared. No partial `done` is produced.

## Timing
- All outputs are registered. An issue decision made in cycle n (from state and `wt_ok`/`dat_ok`) appears on the outputs in cycle n+1.
- Reset values: all outputs 0, `wt_cnt`=0, state IDLE.
- `start` sampled at cycle T gives `busy`=1 at T+1. The earliest `wt_vld` is at T+2, provided `wt_ok` is high at T+1.
- WT→DAT and DAT→WT transitions insert no bubble: the first data beat can follow the last weight beat in the next cycle.
- `done` is asserted exactly DRAIN_CYC+1 cycles after the last `dat_vld` cycle. `busy` drops in the same cycle that `done` is asserted.
- Back-to-back jobs: `start` is accepted at the earliest in the cycle `done` is deasserted.

## Test plan
- TOUT=4, all config fields 0, oks held high:
  - 4 `wt_vld` beats with `wt_cnt`=0,1,2,3;
  - then 1 `dat_vld` with all four flags high;
  - `done` exactly DRAIN_CYC+1 cycles later.
- TOUT=4, wout_max=2, k_max=1, tout_max=0:
  - sequence is W×4, D×3, W×4, D×3;
  - `Wout_loop_start` on data beats 0 and 3;
  - `Wout_loop_end` on beats 2 and 5;
  - `CHinKyKx_max_now` on beats 3–5;
  - `CHinKyKxWout_loop_end` only on beat 5.
- tout_max=2, k_max=0, wout_max=1: `CHinKyKxWout_loop_end` fires 3 times. Totals are 3·TOUT weight beats and 6 data beats.
- Random toggling of `wt_ok`/`dat_ok` (about 50%): beat totals and flag sequence are identical to the unstalled run, and no beat is issued while its ok signal is low.
- Assert `start` mid-job and change the cfg inputs mid-job: no effect on the running sequence or its totals.
- Assert `rst` during DAT: all outputs are 0 in the cycle after `rst`, with no `done`. A new `start` after reset runs a full, correct job.
